dlfloat_dot_mac: RTL and testbench



---
 rtl/dlfloat_pkg.sv | 57 +++++
 rtl/dlfloat_add_core.sv | 80 ++++++++
 rtl/dlfloat_dot_mac.sv | 162 ++++++++++++++++
 tb/tb_dlfloat_dot_mac.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, special encodings, the
// operand struct, the dot-product FSM states and the common result packer
// that applies the overflow / underflow rules.
package dlfloat_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;

  localparam logic [15:0] DLF_NAN  = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO = 16'h0000;

  // {sign, biased exponent, mantissa without the hidden one}
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } dlf_t;

  // Packed result plus the overflow indication raised while packing
  typedef struct packed {
    logic ovf;
    dlf_t val;
  } dlf_pack_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Turn a sign, a widened signed exponent and a truncated mantissa into a
  // DLFloat16 word. Exponents above the top code (or the top code with an
  // all-ones mantissa, which would alias NaN) saturate to NaN and flag
  // overflow. Non-positive exponents either flush to zero or keep their low
  // bits, which reproduces the legacy wrapping behaviour.
  function automatic dlf_pack_t dlf_finish(input logic              sign,
                                           input logic signed [7:0] e,
                                           input logic [MAN_W-1:0]  man,
                                           input logic              flush);
    dlf_pack_t r;
    r.ovf = 1'b0;
    r.val = dlf_t'(DLF_ZERO);
    if ((e > 8'sd63) || ((e == 8'sd63) && (man == '1))) begin
      r.ovf = 1'b1;
      r.val = dlf_t'(DLF_NAN);
    end else if ((e <= 8'sd0) && flush) begin
      r.val = dlf_t'(DLF_ZERO);
    end else begin
      r.val.sign = sign;
      r.val.exp  = e[EXP_W-1:0];
      r.val.man  = man;
    end
    return r;
  endfunction

endpackage

// File: rtl/dlfloat_add_core.sv
// Combinational DLFloat16 adder. Zero and NaN operands short-circuit; the
// smaller magnitude is aligned by truncating right shift, magnitudes are
// added or subtracted, and the result is renormalised through an 11-bit
// leading-one detect. nan reports a NaN operand or an overflowed sum, ovf
// reports the overflow alone.
module dlfloat_add_core
  import dlfloat_pkg::*;
#(
  parameter bit FLUSH_SUBNORM = 1'b1
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        nan,
  output logic        ovf
);

  dlf_t                big;
  dlf_t                sml;
  logic [EXP_W-1:0]    d;
  logic [MAN_W:0]      ms;
  logic [MAN_W+1:0]    mb;
  logic [MAN_W+1:0]    ms_sh;
  logic [MAN_W+1:0]    r;
  logic [3:0]          k;
  logic [MAN_W+1:0]    norm;
  logic signed [7:0]   e;
  dlf_pack_t           pk;

  // Align, add/subtract, renormalise and pack in one combinational pass
  always_comb begin
    sum = DLF_ZERO;
    nan = 1'b0;
    ovf = 1'b0;
    pk  = '0;

    // Larger magnitude first; ties keep a, which only matters for sign when
    // the magnitudes cancel to exactly zero anyway.
    if (b[14:0] > a[14:0]) begin
      big = dlf_t'(b);
      sml = dlf_t'(a);
    end else begin
      big = dlf_t'(a);
      sml = dlf_t'(b);
    end

    d     = big.exp - sml.exp;
    ms    = {1'b1, sml.man};
    ms_sh = (d >= 6'd10) ? '0 : {1'b0, ms >> d};
    mb    = {2'b01, big.man};
    r     = (big.sign == sml.sign) ? (mb + ms_sh) : (mb - ms_sh);

    k = 4'd0;
    for (int i = 0; i < MAN_W + 2; i++) begin
      if (r[i]) k = 4'(i);
    end

    // Leading one lands on bit 10; the hidden one is then bit 10 and the
    // stored mantissa sits in bits 9:1.
    norm = r << (4'd10 - k);
    e    = $signed({2'b00, big.exp}) + $signed({4'b0000, k}) - 8'sd9;

    if ((a == DLF_NAN) || (b == DLF_NAN)) begin
      sum = DLF_NAN;
      nan = 1'b1;
    end else if (a == DLF_ZERO) begin
      sum = b;
    end else if (b == DLF_ZERO) begin
      sum = a;
    end else if (r == '0) begin
      sum = DLF_ZERO;
    end else begin
      pk  = dlf_finish(big.sign, e, MAN_W'(norm >> 1), FLUSH_SUBNORM);
      sum = pk.val;
      nan = pk.ovf;
      ovf = pk.ovf;
    end
  end

endmodule

// File: rtl/dlfloat_dot_mac.sv
// Streaming DLFloat16 dot-product engine. Operand pairs are multiplied into
// a product register, the product is added into the accumulator on the
// following cycle, and the vector closed by in_last is presented on the
// output port until it is taken, after which accumulation restarts at zero.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready depends only on state and rst, never on in_valid;
// out_valid depends only on state, never on out_ready. Once out_valid is
// high, out_data/out_count/out_nan/out_ovf hold until the output transfer.
module dlfloat_dot_mac
  import dlfloat_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter bit FLUSH_SUBNORM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_ovf
);

  state_t            state;
  logic              in_fire;

  // Multiplier (combinational, in front of the product register)
  logic [MAN_W:0]    ma;
  logic [MAN_W:0]    mb;
  logic [19:0]       mp;
  logic signed [7:0] me;
  logic [MAN_W-1:0]  mm;
  dlf_pack_t         mpk;
  logic [15:0]       prod_c;
  logic              prod_nan_c;
  logic              prod_ovf_c;

  // Product register
  logic              p_vld;
  logic              p_last;
  logic [15:0]       p_data;
  logic              p_nan;
  logic              p_ovf;

  // Accumulator and per-vector status
  logic [15:0]       acc;
  logic [CNT_W-1:0]  count;
  logic              nan_f;
  logic              ovf_f;
  logic [15:0]       add_sum;
  logic              add_nan;
  logic              add_ovf;

  assign in_ready  = (state == ACCUM) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_count = count;
  assign out_nan   = nan_f;
  assign out_ovf   = ovf_f;

  // Multiply the incoming pair: 10x10 mantissa product, normalise on bit 19,
  // truncate, then apply the special-operand and range rules
  always_comb begin
    ma = {1'b1, in_a[MAN_W-1:0]};
    mb = {1'b1, in_b[MAN_W-1:0]};
    mp = ma * mb;
    me = $signed({2'b00, in_a[14:9]}) + $signed({2'b00, in_b[14:9]}) - 8'(BIAS);
    if (mp[19]) me = me + 8'sd1;
    mm  = mp[19] ? MAN_W'(mp >> 10) : MAN_W'(mp >> 9);
    mpk = dlf_finish(in_a[15] ^ in_b[15], me, mm, FLUSH_SUBNORM);

    prod_c     = mpk.val;
    prod_nan_c = mpk.ovf;
    prod_ovf_c = mpk.ovf;
    if ((in_a == DLF_NAN) || (in_b == DLF_NAN)) begin
      prod_c     = DLF_NAN;
      prod_nan_c = 1'b1;
      prod_ovf_c = 1'b0;
    end else if ((in_a == DLF_ZERO) || (in_b == DLF_ZERO)) begin
      prod_c     = DLF_ZERO;
      prod_nan_c = 1'b0;
      prod_ovf_c = 1'b0;
    end
  end

  // Register the product of each accepted pair with its framing marker
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      p_data <= DLF_ZERO;
      p_nan  <= 1'b0;
      p_ovf  <= 1'b0;
    end else begin
      p_vld <= in_fire;
      if (in_fire) begin
        p_last <= in_last;
        p_data <= prod_c;
        p_nan  <= prod_nan_c;
        p_ovf  <= prod_ovf_c;
      end
    end
  end

  dlfloat_add_core #(
    .FLUSH_SUBNORM(FLUSH_SUBNORM)
  ) u_add (
    .a  (acc),
    .b  (p_data),
    .sum(add_sum),
    .nan(add_nan),
    .ovf(add_ovf)
  );

  // Vector FSM with the accumulator, pair counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= DLF_ZERO;
      count <= '0;
      nan_f <= 1'b0;
      ovf_f <= 1'b0;
    end else begin
      if (p_vld) begin
        acc   <= add_sum;
        nan_f <= nan_f | p_nan | add_nan;
        ovf_f <= ovf_f | p_ovf | add_ovf;
      end
      if (in_fire && (count != '1)) begin
        count <= count + 1'b1;
      end
      case (state)
        ACCUM: begin
          if (in_fire && in_last) state <= DRAIN;
        end
        DRAIN: begin
          // The closing product is being added this cycle
          if (p_last) state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= DLF_ZERO;
            count <= '0;
            nan_f <= 1'b0;
            ovf_f <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_mac.sv
// Bench for dlfloat_dot_mac: directed scenarios with fixed expected words,
// plus randomized vectors scored against an arithmetic reference model.
module tb_dlfloat_dot_mac;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_nan;
  logic             out_ovf;

  int tests = 0;
  int fails = 0;

  // {ovf, nan, count, data}
  logic [25:0] exp_q[$];

  dlfloat_dot_mac #(
    .CNT_W(CNT_W),
    .FLUSH_SUBNORM(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_nan  (out_nan),
    .out_ovf  (out_ovf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Values are (-1)^s * (512+man)/512 * 2^(e-31); arithmetic is done on
  // integer mantissas with truncation at each step.
  function automatic logic [16:0] finish_ref(input logic s, input int e, input int man);
    if (e > 63 || (e == 63 && man == 511)) return {1'b1, 16'hFFFF};
    if (e <= 0) return 17'h0;
    return {1'b0, s, 6'(e), 9'(man)};
  endfunction

  function automatic void mul_ref(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic n, output logic o);
    int m;
    int e;
    int man;
    logic [16:0] f;
    n = 1'b0;
    o = 1'b0;
    if (a == 16'hFFFF || b == 16'hFFFF) begin
      r = 16'hFFFF;
      n = 1'b1;
      return;
    end
    if (a == 16'h0000 || b == 16'h0000) begin
      r = 16'h0000;
      return;
    end
    m = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (m >= 524288) begin
      man = (m >> 10) - 512;
      e++;
    end else begin
      man = (m >> 9) - 512;
    end
    f = finish_ref(a[15] ^ b[15], e, man);
    r = f[15:0];
    n = f[16];
    o = f[16];
  endfunction

  function automatic void add_ref(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic n, output logic o);
    int ea, eb, ma, mb, eg, mg, es, ms, d, s;
    logic sg, ss;
    logic [16:0] f;
    n = 1'b0;
    o = 1'b0;
    if (a == 16'hFFFF || b == 16'hFFFF) begin
      r = 16'hFFFF;
      n = 1'b1;
      return;
    end
    if (a == 16'h0000) begin
      r = b;
      return;
    end
    if (b == 16'h0000) begin
      r = a;
      return;
    end
    ea = int'(a[14:9]);
    eb = int'(b[14:9]);
    ma = 512 + int'(a[8:0]);
    mb = 512 + int'(b[8:0]);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      eg = ea; mg = ma; sg = a[15]; es = eb; ms = mb; ss = b[15];
    end else begin
      eg = eb; mg = mb; sg = b[15]; es = ea; ms = ma; ss = a[15];
    end
    d = eg - es;
    if (d >= 10) ms = 0;
    else ms = ms >> d;
    s = (sg == ss) ? (mg + ms) : (mg - ms);
    if (s == 0) begin
      r = 16'h0000;
      return;
    end
    while (s >= 1024) begin
      s = s / 2;
      eg++;
    end
    while (s < 512) begin
      s = s * 2;
      eg--;
    end
    f = finish_ref(sg, eg, s - 512);
    r = f[15:0];
    n = f[16];
    o = f[16];
  endfunction

  function automatic logic [15:0] rand_op();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 8)  return 16'h0000;
    if (sel < 11) return 16'hFFFF;
    if (sel < 13) return {1'b0, 6'd62, 9'($urandom_range(0, 511))};
    return {1'($urandom_range(0, 1)), 6'($urandom_range(28, 34)), 9'($urandom_range(0, 511))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: in_ready=0 after %0d cycles, required 1", guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic [15:0] d, output logic [CNT_W-1:0] c,
                             output logic n, output logic o, output int cyc);
    cyc = 0;
    out_ready = 1'b1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL result_timeout: out_valid=0 after %0d cycles, required 1", cyc);
    end
    d = out_data;
    c = out_count;
    n = out_nan;
    o = out_ovf;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    tests++;
    if ({out_valid, out_data, out_count, out_nan, out_ovf} !== 27'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h cnt=%0d nan=%b ovf=%b, required all 0",
               out_valid, out_data, out_count, out_nan, out_ovf);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    out_ready = 1'b1;
    send_pair(16'h3E00, 16'h4000, 1'b0);
    send_pair(16'h3F00, 16'h4000, 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_early_valid: got %b one cycle after last accept, required 0", out_valid);
    end
    wait_result(d, c, n, o, cyc);
    tests++;
    if (cyc !== 1) begin
      fails++;
      $display("[TB] FAIL basic_latency: valid %0d cycles after accept+1, required 1", cyc);
    end
    tests++;
    if (d !== 16'h4280) begin
      fails++;
      $display("[TB] FAIL basic_data: got %h, required 4280", d);
    end
    tests++;
    if ({c, n, o} !== {8'd2, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL basic_count_flags: got cnt=%0d nan=%b ovf=%b, required 2 0 0", c, n, o);
    end
  endtask

  task automatic test_cancel();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    send_pair(16'h4000, 16'h3E00, 1'b0);
    send_pair(16'hBE00, 16'h4000, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, c} !== {16'h0000, 8'd2}) begin
      fails++;
      $display("[TB] FAIL cancel: got data=%h cnt=%0d, required 0000 2", d, c);
    end
  endtask

  task automatic test_nan();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    send_pair(16'hFFFF, 16'h3E00, 1'b0);
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, n, o} !== {16'hFFFF, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL nan_prop: got data=%h nan=%b ovf=%b, required ffff 1 0", d, n, o);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    send_pair(16'h7C00, 16'h7C00, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, n, o} !== {16'hFFFF, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL ovf_result: got data=%h nan=%b ovf=%b, required ffff 1 1", d, n, o);
    end
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, c, n, o} !== {16'h3E00, 8'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL ovf_next_clear: got data=%h cnt=%0d nan=%b ovf=%b, required 3e00 1 0 0", d, c, n, o);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    out_ready = 1'b0;
    send_pair(16'h3E00, 16'h4000, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_hold_reached: out_valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = 16'h3F00;
      in_b     = 16'h3F00;
      in_last  = 1'b1;
      tests++;
      if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 16'h4000, 8'd1}) begin
        fails++;
        $display("[TB] FAIL bp_hold_stable: cycle %0d got valid=%b ready=%b data=%h cnt=%0d, required 1 0 4000 1",
                 i, out_valid, in_ready, out_data, out_count);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, c} !== {16'h3E00, 8'd1}) begin
      fails++;
      $display("[TB] FAIL bp_ignored_pulses: got data=%h cnt=%0d, required 3e00 1", d, c);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    send_pair(16'h3E00, 16'h4000, 1'b0);
    send_pair(16'h3F00, 16'h4000, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rmid_ready: got %b during reset, required 0", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({out_valid, out_data, out_count, out_nan, out_ovf} !== 27'h0) begin
      fails++;
      $display("[TB] FAIL rmid_outputs: got valid=%b data=%h cnt=%0d nan=%b ovf=%b, required all 0",
               out_valid, out_data, out_count, out_nan, out_ovf);
    end
    rst = 1'b0;
    send_pair(16'h3E00, 16'h4000, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, c} !== {16'h4000, 8'd1}) begin
      fails++;
      $display("[TB] FAIL rmid_after: got data=%h cnt=%0d, required 4000 1", d, c);
    end
  endtask

  task automatic test_count_sat();
    logic [15:0] d;
    logic [CNT_W-1:0] c;
    logic n, o;
    int cyc;
    for (int i = 0; i < 259; i++) send_pair(16'h0000, 16'h3E00, 1'b0);
    send_pair(16'h3E00, 16'h3E00, 1'b1);
    wait_result(d, c, n, o, cyc);
    tests++;
    if ({d, c, n, o} !== {16'h3E00, 8'hFF, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL count_sat: got data=%h cnt=%0d nan=%b ovf=%b, required 3e00 255 0 0", d, c, n, o);
    end
  endtask

  // Random back-to-back vectors with random output backpressure
  task automatic test_random(input int nvec);
    int got;
    int cyc;
    logic [25:0] e;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int v = 0; v < nvec; v++) begin
          int len;
          int cnt_m;
          logic [15:0] acc_m, p, a, b, s;
          logic nan_m, ovf_m, pn, po, an, ao;
          len   = $urandom_range(1, 6);
          cnt_m = 0;
          acc_m = 16'h0000;
          nan_m = 1'b0;
          ovf_m = 1'b0;
          for (int k = 0; k < len; k++) begin
            a = rand_op();
            b = rand_op();
            mul_ref(a, b, p, pn, po);
            add_ref(acc_m, p, s, an, ao);
            acc_m = s;
            nan_m = nan_m | pn | an;
            ovf_m = ovf_m | po | ao;
            if (cnt_m < 255) cnt_m++;
            if (k == len - 1) exp_q.push_back({ovf_m, nan_m, 8'(cnt_m), acc_m});
            send_pair(a, b, k == len - 1);
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
          end
        end
      end
      begin
        while (got < nvec && cyc < 5000) begin
          @(posedge clk); #1;
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("[TB] FAIL rand_unexpected: result %h with empty expected queue", out_data);
            end else begin
              e = exp_q.pop_front();
              if ({out_ovf, out_nan, out_count, out_data} !== e) begin
                fails++;
                $display("[TB] FAIL rand_result %0d: got ovf=%b nan=%b cnt=%0d data=%h, required ovf=%b nan=%b cnt=%0d data=%h",
                         got, out_ovf, out_nan, out_count, out_data, e[25], e[24], e[23:16], e[15:0]);
              end
            end
            got++;
          end
        end
        if (got < nvec) begin
          tests++;
          fails++;
          $display("[TB] FAIL rand_timeout: got %0d results, required %0d", got, nvec);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_nan();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_count_sat();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
